stream_mux_arb: RTL
===================

Name: stream_mux_arb

Overview:
- Parametrised N-input, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output.
- Selects one requester per cycle by round-robin or fixed-priority arbitration; a force mode reproduces a plain select-driven mux.
- Holds the winning word in a single output register stage.
- Sits between multiple datapath producers (e.g. instruction fetch and data access) and a shared consumer such as a memory port or register write bus.

Parameters:
- WIDTH, 8, data width per channel.
- NUM_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(NUM_IN), width of channel index fields.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_IN  per-channel request.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-channel accept; one-hot or zero.
- force_en  input  1  when 1, only channel force_sel may be granted.
- force_sel  input  SEL_W  forced channel index.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_sel  output  SEL_W  index of the source of out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, out_sel=0, rr pointer=0.
  - in_ready=0 while rst=1.
  - Reset mid-transfer discards the held word; nothing is replayed.
- Transfers:
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a clock edge.
  - Output transfer: out_valid & out_ready at a clock edge.
- Load enable: load_en = ~out_valid | out_ready. This gives full throughput, one word per cycle, with no bubble when the consumer is always ready.
- Grant (combinational from in_valid, force, and pointer):
  - force_en=1: grant channel force_sel if its valid is 1, else no grant. RR_MODE is ignored and the pointer is not updated.
  - RR_MODE=1: grant the first valid channel searching upward from the pointer with wrap-around (pointer, pointer+1, ..., NUM_IN-1, 0, ...).
  - RR_MODE=0: grant the lowest-index valid channel.
- in_ready[i] = grant[i] & load_en & ~rst. At most one bit set. in_ready may depend combinationally on in_valid; producers must not make in_valid depend on in_ready.
- On an input transfer on channel g:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - RR_MODE=1 and force_en=0: pointer <= (g == NUM_IN-1) ? 0 : g+1.
- Output transfer with no input transfer: out_valid <= 0; out_data and out_sel hold their last values.
- Simultaneous output and input transfer: the register reloads with the new word and out_valid stays 1.
- Stall (out_valid=1, out_ready=0): all in_ready=0; out_data, out_sel and the pointer hold.
- No valid inputs: no grant, and the pointer holds.
- Latency: an input accepted at edge k is visible on out_* after edge k.
- force_sel >= NUM_IN (possible when NUM_IN is not a power of two): no grant.
- Data is not modified. No width conversion; all channels are WIDTH bits.

Decomposition:
- Shared package holds:
  - the stream handshake constants;
  - the arbitration-mode encodings ARB_FIXED=0, ARB_RR=1;
  - a function returning the index of the first set bit at or after a start position with wrap-around.
- One sub-module, rr_arbiter: NUM_IN request bits plus pointer in, one-hot grant and encoded index out, purely combinational.
- The output register, load enable and pointer update live in stream_mux_arb.

Test Plan:
- Reset, then check outputs. Assert rst mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately, before the next edge; in_ready=0 during reset.
- RR arbitration. RR_MODE=1, NUM_IN=4, all in_valid=1, data[i]=8'h10+i, out_ready=1 -> out_data sequence 10,11,12,13,10 on consecutive cycles, with out_sel 0,1,2,3,0.
- Fixed priority. RR_MODE=0, in_valid=4'b1010 -> channel 1 granted every cycle, out_data=8'h11 repeatedly; channel 3 never granted while channel 1 is valid.
- Backpressure. out_ready=0 for 3 cycles after a load -> out_data stable, in_ready=0; release -> the next word loads the same cycle, with no bubble.
- Force mode. force_en=1, force_sel=2, all valid -> only channel 2 granted, out_sel=2 each cycle, pointer unchanged. force_sel=2 with in_valid[2]=0 -> no transfer, out_valid falls after the pending word drains.
- Pointer skip. RR pointer=3, in_valid=4'b0101 -> grant channel 0 (wrap-around), then pointer=1, next grant channel 2.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream multiplexer: handshake constants,
// arbitration mode encodings and a wrap-around first-set search.
package stream_mux_arb_pkg;

    // Stream handshake levels
    localparam logic HS_VALID = 1'b1;
    localparam logic HS_READY = 1'b1;

    // Arbitration mode encodings (value of RR_MODE)
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Widest request vector the search helper supports
    localparam int MAX_REQ = 64;

    // Index of the first set bit of req[n-1:0] at or after start, wrapping
    // past n-1 back to 0. Returns n when no bit is set. start must be < n.
    function automatic logic [6:0] first_set_wrap(input logic [63:0] req,
                                                  input logic [6:0]  start,
                                                  input logic [6:0]  n);
        logic [6:0] idx;
        logic [6:0] res;
        logic       found;
        res   = n;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = start + 7'(k);
            if (idx >= n) idx = idx - n;
            if (!found && (7'(k) < n) && req[idx[5:0]]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational wrap-around arbiter: grants the first requester at or after
// the pointer. A zero pointer turns it into a lowest-index-wins arbiter.
module rr_arbiter
    import stream_mux_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              any_o
);

    localparam logic [6:0] N7 = 7'(NUM_IN);

    logic [6:0] first;

    // Search upward from the pointer and encode the winner both ways
    always_comb begin
        first   = first_set_wrap(64'(req_i), 7'(ptr_i), N7);
        any_o   = (first != N7);
        idx_o   = SEL_W'(first);
        grant_o = any_o ? (NUM_IN'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-input registered stream multiplexer. One requester is granted per cycle
// (round-robin, fixed priority, or forced channel) and its word is held in a
// single output register that reloads whenever it is empty or being drained.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = $clog2(NUM_IN),
    parameter int RR_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic                           out_valid_q, out_valid_d;
    logic [WIDTH-1:0]               out_data_q,  out_data_d;
    logic [SEL_W-1:0]               out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]               ptr_q,       ptr_d;

    logic [NUM_IN-1:0][WIDTH-1:0]   chan;
    logic [NUM_IN-1:0]              req;
    logic [SEL_W-1:0]               arb_ptr;
    logic [NUM_IN-1:0]              grant;
    logic [SEL_W-1:0]               gidx;
    logic                           gany;
    logic                           load_en;
    logic                           xfer;

    assign chan = in_data;

    // Request masking and handshake: force narrows the request set to one
    // channel (an out-of-range force_sel shifts the bit out, so no grant).
    // Fixed priority is the same search started from channel 0.
    always_comb begin
        req      = force_en ? (in_valid & (NUM_IN'(1) << force_sel)) : in_valid;
        arb_ptr  = (RR_MODE == ARB_RR) ? ptr_q : '0;
        load_en  = (out_valid_q != HS_VALID) || (out_ready == HS_READY);
        xfer     = gany && load_en;
        in_ready = grant & {NUM_IN{load_en & ~rst}};
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (arb_ptr),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    // Next state of the output register and round-robin pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = chan[gidx];
            out_sel_d   = gidx;
            if ((RR_MODE == ARB_RR) && !force_en)
                ptr_d = (gidx == SEL_W'(NUM_IN - 1)) ? '0 : gidx + SEL_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held word without replay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
